// File: rtl/sig_div_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package sig_div_pkg;

    localparam int unsigned DW_DEF = 19;
    localparam int unsigned VW_DEF = 9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StZero = 2'd3
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/sig_div_abs.sv
// Conditional two's-complement negate; o_sign reports the input MSB.
module sig_div_abs #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val,
    output logic         o_sign
);

    assign o_sign = i_val[W-1];
    assign o_val  = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/sig_seq_divider.sv
// Radix-2 restoring signed divider: one quotient bit per enabled clock, then sign fix-up.
module sig_seq_divider
    import sig_div_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned VW = VW_DEF
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          clken,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          overflow
);

    localparam int unsigned CW = cnt_w(DW);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [VW-1:0] r_prem;
    logic [DW-1:0] r_qmag;
    logic [VW-1:0] r_bmag;
    logic          r_sa;
    logic          r_sb;
    logic          r_ovf_pend;
    logic          r_busy;
    logic          r_done;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_dbz;
    logic          r_ovf;

    logic          w_fix;
    logic [DW-1:0] w_a_in;
    logic          w_a_neg;
    logic [DW-1:0] w_a_val;
    logic          w_a_sign;
    logic [VW-1:0] w_b_in;
    logic          w_b_neg;
    logic [VW-1:0] w_b_val;
    logic          w_b_sign;
    logic          w_b_zero;
    logic          w_ovf_in;
    logic [VW:0]   w_shift;
    logic [VW:0]   w_trial;

    // Both negators are shared: magnitudes at capture, sign fix-up in FIX.
    assign w_fix   = (r_state == StFix);
    assign w_a_in  = w_fix ? r_qmag : dividend;
    assign w_a_neg = w_fix ? (r_sa ^ r_sb) : dividend[DW-1];
    assign w_b_in  = w_fix ? r_prem : divisor;
    assign w_b_neg = w_fix ? r_sa : divisor[VW-1];

    sig_div_abs #(.W(DW)) u_abs_a (
        .i_val  (w_a_in),
        .i_neg  (w_a_neg),
        .o_val  (w_a_val),
        .o_sign (w_a_sign)
    );

    sig_div_abs #(.W(VW)) u_abs_b (
        .i_val  (w_b_in),
        .i_neg  (w_b_neg),
        .o_val  (w_b_val),
        .o_sign (w_b_sign)
    );

    assign w_b_zero = (divisor == '0);
    assign w_ovf_in = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
    assign w_shift  = {r_prem, r_qmag[DW-1]};
    assign w_trial  = w_shift - {1'b0, r_bmag};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_nxt = w_b_zero ? StZero : StRun;
            StRun:   if (r_cnt == '0) w_state_nxt = StFix;
            StFix:   w_state_nxt = StIdle;
            StZero:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_prem     <= '0;
            r_qmag     <= '0;
            r_bmag     <= '0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (clken) begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (!w_b_zero) begin
                            r_qmag     <= w_a_val;
                            r_bmag     <= w_b_val;
                            r_sa       <= w_a_sign;
                            r_sb       <= w_b_sign;
                            r_prem     <= '0;
                            r_cnt      <= CW'(DW - 1);
                            r_ovf_pend <= w_ovf_in;
                        end
                    end
                end
                StRun: begin
                    // Restoring step: keep the shifted value when the trial goes negative.
                    r_prem <= w_trial[VW] ? w_shift[VW-1:0] : w_trial[VW-1:0];
                    r_qmag <= {r_qmag[DW-2:0], ~w_trial[VW]};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                StFix: begin
                    r_quot <= w_a_val;
                    r_rem  <= w_b_val;
                    r_ovf  <= r_ovf_pend;
                    r_dbz  <= 1'b0;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                StZero: begin
                    r_quot <= '1;
                    r_rem  <= '0;
                    r_dbz  <= 1'b1;
                    r_ovf  <= 1'b0;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_sig_seq_divider.sv
// Randomized and directed bench for sig_seq_divider against an integer-arithmetic model.
module tb_sig_seq_divider;

    localparam int DW = 19;
    localparam int VW = 9;

    logic          clk = 1'b0;
    logic          aclr;
    logic          clken;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sig_seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .clken       (clken),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                  output logic [DW-1:0] q, output logic [VW-1:0] r,
                                  output logic dz, output logic ov);
        int ai;
        int bi;
        ai = $signed(a);
        bi = $signed(b);
        if (bi == 0) begin
            q = '1; r = '0; dz = 1'b1; ov = 1'b0;
        end else begin
            q  = DW'(ai / bi);
            r  = VW'(ai % bi);
            dz = 1'b0;
            ov = (ai == -(1 << (DW - 1))) && (bi == -1);
        end
    endfunction

    // Called at posedge+1; the start is accepted at the next posedge.
    task automatic launch(input logic [DW-1:0] a, input logic [VW-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        aclr = 1'b1; clken = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #3;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {busy, done, quotient, remainder, div_by_zero, overflow});
        end
        step(3);
        aclr = 1'b0;
        step(2);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy/done got %b required 00", {busy, done});
        end
    endtask

    task automatic test_directed;
        int ta[7] = '{100, -100, 100, -100, -262144, 262143, 5};
        int tb[7] = '{7, 7, -7, -7, -1, -256, 0};
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic edz, eov;
        int n, lat;
        for (int i = 0; i < 7; i++) begin
            launch(DW'(ta[i]), VW'(tb[i]));
            wait_done(n);
            model(DW'(ta[i]), VW'(tb[i]), eq, er, edz, eov);
            lat = edz ? 1 : DW + 1;
            n_checks++;
            if (n !== lat) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: got %0d required %0d", i, n, lat);
            end
            n_checks++;
            if ({quotient, remainder, div_by_zero, overflow, busy} !== {eq, er, edz, eov, 1'b0}) begin
                n_fail++;
                $display("FAIL dir_result[%0d] %0d/%0d: got q=%h r=%h dz=%b ov=%b busy=%b required q=%h r=%h dz=%b ov=%b",
                         i, ta[i], tb[i], quotient, remainder, div_by_zero, overflow, busy,
                         eq, er, edz, eov);
            end
            step(1);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_done_pulse[%0d]: got %b required 0", i, done);
            end
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] a, eq;
        logic [VW-1:0] b, er;
        logic edz, eov;
        int n, lat;
        for (int i = 0; i < 40; i++) begin
            a = DW'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
            launch(a, b);
            wait_done(n);
            model(a, b, eq, er, edz, eov);
            lat = edz ? 1 : DW + 1;
            n_checks++;
            if (n !== lat || {quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
                n_fail++;
                $display("FAIL rand[%0d] %h/%h: got lat=%0d q=%h r=%h dz=%b ov=%b required lat=%0d q=%h r=%h dz=%b ov=%b",
                         i, a, b, n, quotient, remainder, div_by_zero, overflow,
                         lat, eq, er, edz, eov);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic edz, eov;
        int n;
        launch(DW'(1000), VW'(9));
        wait_done(n);
        launch(DW'(-5000), VW'(37));
        n_checks++;
        if ({done, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_accept: done/busy got %b required 01", {done, busy});
        end
        wait_done(n);
        model(DW'(-5000), VW'(37), eq, er, edz, eov);
        n_checks++;
        if (n !== DW + 1 || {quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h required lat=%0d q=%h r=%h",
                     n, quotient, remainder, DW + 1, eq, er);
        end
    endtask

    task automatic test_start_while_busy;
        logic [DW-1:0] eq, pq;
        logic [VW-1:0] er, pr;
        logic edz, eov;
        int n;
        launch(DW'(777), VW'(-3));
        wait_done(n);
        model(DW'(777), VW'(-3), pq, pr, edz, eov);
        launch(DW'(12345), VW'(-77));
        step(3);
        for (int k = 0; k < 5; k++) begin
            dividend = DW'($urandom);
            divisor  = (k % 2 == 0) ? '0 : VW'($urandom);
            start    = 1'b1;
            step(1);
            start = 1'b0;
            step(1);
        end
        n_checks++;
        if ({quotient, remainder, busy} !== {pq, pr, 1'b1}) begin
            n_fail++;
            $display("FAIL busy_hold: got q=%h r=%h busy=%b required q=%h r=%h busy=1",
                     quotient, remainder, busy, pq, pr);
        end
        wait_done(n);
        model(DW'(12345), VW'(-77), eq, er, edz, eov);
        n_checks++;
        if (n + 13 !== DW + 1 || {quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
            n_fail++;
            $display("FAIL busy_ignore: got lat=%0d q=%h r=%h required lat=%0d q=%h r=%h",
                     n + 13, quotient, remainder, DW + 1, eq, er);
        end
    endtask

    task automatic test_clken_stall;
        logic [DW-1:0] eq, hq;
        logic [VW-1:0] er, hr;
        logic edz, eov;
        int n;
        launch(DW'(-200000), VW'(113));
        step(5);
        hq = quotient; hr = remainder;
        clken = 1'b0;
        step(7);
        n_checks++;
        if ({quotient, remainder, busy, done} !== {hq, hr, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_freeze: got q=%h r=%h busy=%b done=%b required q=%h r=%h busy=1 done=0",
                     quotient, remainder, busy, done, hq, hr);
        end
        clken = 1'b1;
        wait_done(n);
        model(DW'(-200000), VW'(113), eq, er, edz, eov);
        n_checks++;
        if (n + 12 !== DW + 1 + 7 || {quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
            n_fail++;
            $display("FAIL stall_result: got lat=%0d q=%h r=%h required lat=%0d q=%h r=%h",
                     n + 12, quotient, remainder, DW + 8, eq, er);
        end
        clken = 1'b0;
        step(3);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done_hold: got %b required 1", done);
        end
        clken = 1'b1;
        step(1);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done_clear: got %b required 0", done);
        end
    endtask

    task automatic test_abort;
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic edz, eov;
        int n, seen;
        launch(DW'(99999), VW'(55));
        step(9);
        aclr = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: got %h required 0",
                     {busy, done, quotient, remainder, div_by_zero, overflow});
        end
        @(posedge clk); #1;
        aclr = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done cycles required 0", seen);
        end
        launch(DW'(99999), VW'(55));
        wait_done(n);
        model(DW'(99999), VW'(55), eq, er, edz, eov);
        n_checks++;
        if (n !== DW + 1 || {quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
            n_fail++;
            $display("FAIL abort_restart: got lat=%0d q=%h r=%h required lat=%0d q=%h r=%h",
                     n, quotient, remainder, DW + 1, eq, er);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_clken_stall();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
